// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that sits between a host writer and a UART
// transmitter. The head byte is presented combinationally on m_data/m_valid
// and leaves on an m_valid & m_ready handshake. A write into a full FIFO
// with no same-cycle pop is dropped and latches the sticky overflow flag.
// Optional feature: define UART_TXF_DROP_CNT_EN to add an 8-bit saturating
// drop_count output that counts dropped writes.
module uart_tx_fifo #(
  parameter int DEPTH           = 16,
  parameter int ALMOST_FULL_LVL = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     flush,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     overflow
`ifdef UART_TXF_DROP_CNT_EN
  ,
  output logic [7:0]               drop_count
`endif
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]     AF_LVL  = (AW+1)'(ALMOST_FULL_LVL);

  // Saturating increment for the 8-bit drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          pop, push, drop;

  // Handshake decode: a pop frees a slot in the same cycle, so a write to a
  // full FIFO is still accepted when the head is leaving.
  always_comb begin
    pop  = (cnt_q != '0) && m_ready;
    push = wr_en && ((cnt_q != DEPTH_L) || pop);
    drop = wr_en && (cnt_q == DEPTH_L) && !pop;
  end

  // Next-state for pointers, occupancy and overflow; flush wins over traffic.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
      else if (!push && pop) cnt_d = cnt_q - (AW+1)'(1);
      if (drop) ovf_d = 1'b1;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage array; no reset, only written on an accepted write.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem_q[wptr_q] <= wr_data;
  end

`ifdef UART_TXF_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  // Drop counter next-state: cleared by flush, saturating on each drop.
  always_comb begin
    drop_d = drop_q;
    if (flush)     drop_d = 8'd0;
    else if (drop) drop_d = sat_inc8(drop_q);
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) drop_q <= 8'd0;
    else     drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`endif

  assign m_valid     = (cnt_q != '0);
  assign m_data      = mem_q[rptr_q];
  assign level       = cnt_q;
  assign full        = (cnt_q == DEPTH_L);
  assign empty       = (cnt_q == '0);
  assign almost_full = (cnt_q >= AF_LVL);
  assign overflow    = ovf_q;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; the value SHALL be a power of two and at least 4.
REQ-002 Parameter ALMOST_FULL_LVL, default 12, level at or above which almost_full SHALL assert.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port wr_en  input  1  write strobe from the host side.
REQ-006 Port wr_data  input  8  byte to enqueue.
REQ-007 Port flush  input  1  discard all stored bytes.
REQ-008 Port m_data  output  8  head byte, driven to the UART transmitter tx_data.
REQ-009 Port m_valid  output  1  head byte present, driven to the transmitter tx_valid.
REQ-010 Port m_ready  input  1  consumer accept, from the transmitter tx_ready.
REQ-011 Port level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 Port full  output  1  level == DEPTH.
REQ-013 Port empty  output  1  level == 0.
REQ-014 Port almost_full  output  1  level >= ALMOST_FULL_LVL.
REQ-015 Port overflow  output  1  sticky flag: a write was dropped.

Function
REQ-016 The block SHALL be a circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-017 A write SHALL be accepted when wr_en=1 and either full=0, or full=1 with a same-cycle pop.
REQ-018 A pop SHALL occur when m_valid=1 and m_ready=1, and SHALL advance the read pointer by one.
REQ-019 m_valid SHALL equal !empty, and m_data SHALL equal the entry at the read pointer, combinationally from state.
REQ-020 A byte written in cycle N SHALL appear on m_data with m_valid=1 in cycle N+1 when the FIFO was empty; write-to-output latency SHALL be 1 cycle.
REQ-021 A simultaneous accepted write and pop SHALL leave level unchanged.
REQ-022 On an empty FIFO, a write with m_ready=1 SHALL NOT pop the incoming byte in the same cycle.
REQ-023 A write with full=1 and no pop SHALL be dropped, leaving memory and pointers unchanged, and SHALL set overflow=1 in the next cycle.
REQ-024 overflow SHALL remain set until rst or flush.
REQ-025 level, full, empty and almost_full SHALL be registered or derived from registered pointers and count, and SHALL reflect each accepted write or pop one cycle later.
REQ-026 flush=1 SHALL take priority over a same-cycle write and pop, and SHALL reset both pointers, set level=0 and clear overflow next cycle.
REQ-027 m_data SHALL be ignored by consumers while m_valid=0; its value then is don't-care.
REQ-028 Bytes SHALL leave in exactly the order they were accepted; no byte SHALL be duplicated or lost except a dropped write.

Reset
REQ-029 In the cycle after rst=1, the outputs SHALL be: level=0, empty=1, full=0, almost_full=0, m_valid=0, overflow=0.
REQ-030 Reset SHALL clear the pointers, and a write or pop presented during rst=1 SHALL be ignored.
REQ-031 Memory contents SHALL NOT require reset.
REQ-032 rst asserted mid-stream SHALL discard all stored bytes.

Configuration
REQ-033 Macro UART_TXF_DROP_CNT_EN, when defined, SHALL add port drop_count (output, 8 bits).
REQ-034 drop_count SHALL increment once per dropped write and saturate at 255.
REQ-035 drop_count SHALL be cleared to 0 by rst or flush.
REQ-036 When UART_TXF_DROP_CNT_EN is not defined, port drop_count and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-037 Reset, then write 0x55 with m_ready=0 -> next cycle m_valid=1, m_data=0x55, level=1, empty=0.
REQ-038 Write 16 bytes 0x00..0x0F with m_ready=0 -> full=1, level=16, almost_full asserted from level 12; a 17th write of 0xAA -> overflow=1, level=16, drop_count=1 if UART_TXF_DROP_CNT_EN is defined.
REQ-039 With the FIFO full, hold wr_en=1 with data 0x80 and m_ready=1 for one cycle -> 0x00 popped, 0x80 stored, level=16, overflow unchanged.
REQ-040 Stream 40 bytes with m_ready toggling 1-0-1-0 -> output sequence equals input order exactly, pointers wrap, and level never exceeds 16.
REQ-041 With level=5, assert flush together with wr_en=1 and m_ready=1 -> next cycle level=0, empty=1, m_valid=0, overflow=0.
REQ-042 Assert rst with level=7 -> next cycle level=0 and m_valid=0, and a write after reset release is the next head byte.
